out_of_buff_ctrl: RTL
=====================

Name: out_of_buff_ctrl

Overview:
Sequencer that drives the consecutive-number generator and lane-select mux array. It walks a buffer index range and emits, per beat, the base index N and the per-lane select fields. A valid/ready handshake gates each beat toward the downstream consumer. It has two modes: stream (distinct consecutive indices per lane) and broadcast (all lanes read the same index).

Parameters:
SIZE, 16, index range 0..SIZE-1; must be a power of two; IW = $clog2(SIZE)
J, 4, number of output lanes (1..4); L = J is the maximum number of elements issued per stream beat
MAX_CNT, 255, largest transfer length; CW = $clog2(MAX_CNT+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
base  input  IW  first buffer index of the transfer
count  input  CW  number of elements to issue
mode  input  1  0 = stream, 1 = broadcast
N  output  IW  base number fed to the generator
sel_flat  output  J*2  lane j select in bits [2j+1:2j]
lane_valid  output  J  per-lane element-valid mask
out_valid  output  1  beat valid
out_ready  input  1  consumer accepts the beat
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset (any time, asynchronous): state IDLE, N=0, sel_flat=0, lane_valid=0, out_valid=0, busy=0, done=0, internal ptr/rem/off=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, count>0: latch base, count and mode; ptr=base, rem=count, off=0. Next cycle is RUN with out_valid=1, giving 1-cycle start-to-first-beat latency.
- IDLE, start=1, count=0: next cycle is DONE (done=1). No beat is issued.
- start is ignored outside IDLE.
- RUN: busy=1, out_valid=1. A beat is accepted on out_valid & out_ready. While out_ready=0, N, sel_flat and lane_valid hold stable.
- Stream mode, per beat:
  - k = min(J, rem); N = ptr.
  - For j<k: sel_j = j, lane_valid[j] = 1. For j>=k: sel_j = 0, lane_valid[j] = 0.
  - On accept: ptr = (ptr+k) mod SIZE, rem = rem-k.
- Broadcast mode, per beat:
  - N = ptr; every sel_j = off; lane_valid = all ones.
  - On accept: rem = rem-1. If off=3 then off=0 and ptr = (ptr+4) mod SIZE; otherwise off = off+1.
- If an accepted beat brings rem to 0, the next cycle is DONE. In DONE: out_valid=0, lane_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- The beat presented after an accept reflects the updated ptr/rem/off on the very next cycle, so accepts can be back-to-back.
- Index wrap is pure modulo SIZE. The generator's own wrap of N+1..N+3 is not corrected here.
- In IDLE/DONE, N and sel_flat hold their last values. Only out_valid and lane_valid are forced to 0.
- Reset during RUN aborts immediately to IDLE with all outputs zero. No done pulse is produced.
- A start coinciding with the DONE cycle is ignored.

Test Plan:
- Stream, J=4, base=3, count=10, out_ready=1: beats (N=3, lanes 1111), (7, 1111), (11, 0011 with sel 0,1). done is high on the cycle after the third beat; busy is low there.
- Stream wrap, SIZE=16, base=14, count=6: beats (N=14, 1111) and (N=2, 0011). ptr wraps from 18 to 2.
- Broadcast, base=5, count=6: (N,sel) sequence (5,0), (5,1), (5,2), (5,3), (9,0), (9,1), all lanes valid. done follows the sixth beat.
- Backpressure: stream, base=0, count=8; hold out_ready=0 for 3 cycles during beat 1. N=0 and sel/lane_valid stay constant. Beat 2 appears with N=4 on the cycle after out_ready rises.
- count=0: start -> no out_valid at any time; done=1 exactly one cycle after start.
- Reset mid-run: assert rst during beat 2 of a count=12 transfer. All outputs are 0 immediately, there is no done pulse, and a new start afterwards runs normally from its own base.

Source files
------------

// File: rtl/out_of_buff_ctrl.sv
// Beat sequencer for the consecutive-number generator and lane-select mux array.
// Walks a buffer index range in stream or broadcast mode behind a valid/ready handshake.
module out_of_buff_ctrl #(
    parameter int SIZE    = 16,
    parameter int J       = 4,
    parameter int MAX_CNT = 255,
    localparam int IW     = $clog2(SIZE),
    localparam int CW     = $clog2(MAX_CNT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IW-1:0]   base,
    input  logic [CW-1:0]   count,
    input  logic            mode,
    output logic [IW-1:0]   N,
    output logic [2*J-1:0]  sel_flat,
    output logic [J-1:0]    lane_valid,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LANES = CW'(J);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   rem;
    logic [1:0]      off;
    logic            mode_r;

    logic [CW-1:0]   k;
    logic [IW-1:0]   nxt_ptr;
    logic [CW-1:0]   nxt_rem;
    logic [1:0]      nxt_off;

    logic [IW-1:0]   src_ptr;
    logic [CW-1:0]   src_rem;
    logic [1:0]      src_off;
    logic            src_mode;
    logic [CW-1:0]   src_k;
    logic [2*J-1:0]  beat_sel;
    logic [J-1:0]    beat_lv;

    // Pointer/remaining/offset after the current beat is accepted; wrap is plain mod SIZE.
    always_comb begin
        k       = (rem < LANES) ? rem : LANES;
        nxt_ptr = ptr + IW'(k);
        nxt_rem = rem - k;
        nxt_off = off;
        if (mode_r) begin
            nxt_rem = rem - CW'(1);
            if (off == 2'd3) begin
                nxt_off = 2'd0;
                nxt_ptr = ptr + IW'(4);
            end else begin
                nxt_off = off + 2'd1;
                nxt_ptr = ptr;
            end
        end
    end

    // Next beat comes from the start request in IDLE, otherwise from the post-accept values.
    always_comb begin
        src_ptr  = nxt_ptr;
        src_rem  = nxt_rem;
        src_off  = nxt_off;
        src_mode = mode_r;
        if (state == IDLE) begin
            src_ptr  = base;
            src_rem  = count;
            src_off  = 2'd0;
            src_mode = mode;
        end
        src_k    = (src_rem < LANES) ? src_rem : LANES;
        beat_sel = '0;
        beat_lv  = '0;
        for (int j = 0; j < J; j++) begin
            if (src_mode) begin
                beat_sel[2*j +: 2] = src_off;
                beat_lv[j]         = 1'b1;
            end else if (CW'(j) < src_k) begin
                beat_sel[2*j +: 2] = 2'(j);
                beat_lv[j]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            rem        <= '0;
            off        <= '0;
            mode_r     <= 1'b0;
            N          <= '0;
            sel_flat   <= '0;
            lane_valid <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (count != '0) begin
                            ptr        <= base;
                            rem        <= count;
                            off        <= 2'd0;
                            mode_r     <= mode;
                            N          <= src_ptr;
                            sel_flat   <= beat_sel;
                            lane_valid <= beat_lv;
                            out_valid  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        ptr <= nxt_ptr;
                        rem <= nxt_rem;
                        off <= nxt_off;
                        if (nxt_rem == '0) begin
                            out_valid  <= 1'b0;
                            lane_valid <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            N          <= src_ptr;
                            sel_flat   <= beat_sel;
                            lane_valid <= beat_lv;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
